// File: rtl/ifu_pkg.sv
// Shared fetch-unit types for the return address stack and its backend checkpoints.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ifu_pkg;

  localparam int RAS_DEPTH = 16;
  localparam int RAS_PTR_W = $clog2(RAS_DEPTH);

  typedef logic [RAS_PTR_W-1:0] ras_ptr_t;
  typedef logic [RAS_PTR_W:0]   ras_cnt_t;

  // Pointer snapshot carried by each in-flight branch so a redirect can rewind the stack.
  typedef struct packed {
    ras_ptr_t top;
    ras_cnt_t cnt;
  } ras_ckpt_t;

endpackage

// File: rtl/ifu_ras.sv
// Return address stack: pushes pc+8 on link and predicts the target of returns.
// Latency: prediction is combinational from current state; updates land on the next clk edge.
// Backpressure: state only moves on req_valid & req_fire; a stalled fetch holds everything.
module ifu_ras
  import ifu_pkg::*;
#(
  parameter  int DEPTH = RAS_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [31:0]      req_pc,
  input  logic             req_is_link,
  input  logic             req_is_ret,
  input  logic             req_fire,
  output logic [31:0]      ret_target,
  output logic             ret_valid,
  output logic [PTR_W-1:0] ckpt_top,
  output logic [PTR_W:0]   ckpt_cnt,
  input  logic             recover,
  input  logic [PTR_W-1:0] recover_top,
  input  logic [PTR_W:0]   recover_cnt
);

  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ZERO = '0;
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [PTR_W-1:0] top_q, top_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic [31:0]      stack_q [DEPTH];
  logic [31:0]      stack_d [DEPTH];

  logic [31:0]      link_addr;
  logic [PTR_W-1:0] top_inc;
  logic [PTR_W-1:0] top_dec;

  // Prediction reads the pre-update state so a same-cycle JALR $ra,$ra sees the old top.
  assign ret_target = stack_q[top_q];
  assign ret_valid  = req_valid & req_is_ret & (cnt_q != CNT_ZERO);
  assign ckpt_top   = top_q;
  assign ckpt_cnt   = cnt_q;

  // Next-state: recover wins over any request; pointers wrap naturally at PTR_W bits.
  always_comb begin
    link_addr = req_pc + 32'd8;
    top_inc   = top_q + PTR_ONE;
    top_dec   = top_q - PTR_ONE;
    top_d     = top_q;
    cnt_d     = cnt_q;
    stack_d   = stack_q;

    if (recover) begin
      top_d = recover_top;
      cnt_d = (recover_cnt > CNT_FULL) ? CNT_FULL : recover_cnt;
    end else if (req_valid && req_fire) begin
      case ({req_is_link, req_is_ret})
        2'b10: begin
          // Push; when full the new entry overwrites the oldest one.
          top_d            = top_inc;
          stack_d[top_inc] = link_addr;
          if (cnt_q != CNT_FULL) cnt_d = cnt_q + CNT_ONE;
        end
        2'b01: begin
          // Pop; an empty stack is left alone.
          if (cnt_q != CNT_ZERO) begin
            top_d = top_dec;
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        2'b11: begin
          // Call-through-return: replace the top entry in place.
          stack_d[top_q] = link_addr;
          if (cnt_q == CNT_ZERO) cnt_d = CNT_ONE;
        end
        default: begin
        end
      endcase
    end
  end

  // State register for pointers, occupancy and the entry array.
  always_ff @(posedge clk) begin
    if (rst) begin
      top_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= 32'h0;
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= stack_d[i];
    end
  end

endmodule
